// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types and constants for the keypad debounce slice.
//               Holds the controller state encoding, the "no key" code the
//               scanner emits and the raw/digit code widths.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    localparam int RAW_W   = 5;
    localparam int DIGIT_W = 4;

    // Scanner code meaning "no key pressed".
    localparam logic [RAW_W-1:0] KEY_NONE = 5'b11111;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_HELD       = 2'd2,
        ST_RELEASE_DB = 2'd3
    } state_t;

endpackage : keypad_pkg
`default_nettype wire

// File: rtl/keypad_debounce_digit_history.sv
`default_nettype none
// ============================================================================
// Module      : digit_history
// Description : Two-stage 4-bit shift register keeping the newest and the
//               previous accepted key for the dual seven-segment display.
// Ports       : clk       - system clock
//               reset     - asynchronous, active-high reset
//               shift_en  - push din in, move digit_new into digit_old
//               din       - key code to push
//               digit_new - most recently pushed key
//               digit_old - key pushed before digit_new
// Revision    : 1.0 - initial release
// ============================================================================
module digit_history
    import keypad_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               shift_en,
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] digit_new,
    output logic [DIGIT_W-1:0] digit_old
);

    logic [DIGIT_W-1:0] r_new;
    logic [DIGIT_W-1:0] r_old;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_new <= '0;
            r_old <= '0;
        end else if (shift_en) begin
            r_old <= r_new;
            r_new <= din;
        end
    end

    assign digit_new = r_new;
    assign digit_old = r_old;

endmodule : digit_history
`default_nettype wire

// File: rtl/keypad_debounce.sv
`default_nettype none
// ============================================================================
// Module      : keypad_debounce
// Description : Debounces the keypad scanner output in both directions and
//               emits one key_pulse per accepted press, while keeping a
//               two-digit key history for the display stage.
// Ports       : clk        - system clock
//               reset      - asynchronous, active-high reset
//               keypad_val - raw scanner code (0-15 key, 31 none)
//               key_onebit - scanner press flag
//               key_pulse  - one-cycle strobe on key acceptance
//               key_held   - high while an accepted key is down
//               digit_new  - most recently accepted key
//               digit_old  - key accepted before digit_new
// Options     : KEYPAD_REPEAT_EN - when defined, a held key re-issues
//               key_pulse (and a history shift) every REPEAT_CYCLES cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 60000,
    parameter int REPEAT_CYCLES   = 3000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [RAW_W-1:0]   keypad_val,
    input  logic               key_onebit,
    output logic               key_pulse,
    output logic               key_held,
    output logic [DIGIT_W-1:0] digit_new,
    output logic [DIGIT_W-1:0] digit_old
);

    localparam int c_cnt_w = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_db_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [DIGIT_W-1:0]   r_cand;
    logic [DIGIT_W-1:0]   w_cand_nxt;
    logic                 w_accept;
    logic                 w_rep_fire;
    logic                 w_shift;
    logic                 r_pulse;
    logic                 r_held;

    // ------------------------------------------------------------------
    // Debounce state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_cand  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cand  <= w_cand_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cand_nxt  = r_cand;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (key_onebit) begin
                    w_cand_nxt  = keypad_val[DIGIT_W-1:0];
                    w_cnt_nxt   = c_cnt_one;
                    w_state_nxt = ST_PRESS_DB;
                end
            end
            ST_PRESS_DB: begin
                // Full 5-bit compare: a valid key always has bit 4 clear.
                if (!key_onebit || (keypad_val != {1'b0, r_cand})) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == c_db_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_HELD;
                    w_accept    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            ST_HELD: begin
                // Code changes while held are ignored; only a release counts.
                if (!key_onebit) begin
                    w_cnt_nxt   = c_cnt_one;
                    w_state_nxt = ST_RELEASE_DB;
                end
            end
            ST_RELEASE_DB: begin
                if (key_onebit) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_HELD;
                end else if (r_cnt == c_db_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Optional auto-repeat while a key stays held
    // ------------------------------------------------------------------
`ifdef KEYPAD_REPEAT_EN
    localparam int c_rep_w = $clog2(REPEAT_CYCLES + 1);
    localparam logic [c_rep_w-1:0] c_rep_last = c_rep_w'(REPEAT_CYCLES - 1);

    logic [c_rep_w-1:0] r_rep;
    logic [c_rep_w-1:0] w_rep_nxt;

    // Cleared whenever the controller is not resting in HELD, so a release
    // bounce restarts the interval from zero.
    always_comb begin
        w_rep_nxt  = '0;
        w_rep_fire = 1'b0;
        if (r_state == ST_HELD && key_onebit) begin
            if (r_rep == c_rep_last) begin
                w_rep_fire = 1'b1;
            end else begin
                w_rep_nxt = r_rep + c_rep_w'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rep <= '0;
        end else begin
            r_rep <= w_rep_nxt;
        end
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    // Accept and repeat are mutually exclusive (PRESS_DB vs HELD), so at
    // most one history shift happens per cycle.
    assign w_shift = w_accept | w_rep_fire;

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pulse <= 1'b0;
            r_held  <= 1'b0;
        end else begin
            r_pulse <= w_shift;
            r_held  <= (w_state_nxt == ST_HELD) || (w_state_nxt == ST_RELEASE_DB);
        end
    end

    // r_cand already holds the accepted code on both accept and repeat edges.
    digit_history u_digit_history (
        .clk       (clk),
        .reset     (reset),
        .shift_en  (w_shift),
        .din       (r_cand),
        .digit_new (digit_new),
        .digit_old (digit_old)
    );

    assign key_pulse = r_pulse;
    assign key_held  = r_held;

endmodule : keypad_debounce
`default_nettype wire
